// File: rtl/cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// cpu_run_monitor
//
// Launches and supervises one run of a small CPU core. A start pulse holds
// the core in reset for RST_CYCLES cycles. The core then runs until its PC
// reaches HALT_PC or until TIMEOUT run cycles have elapsed. While it runs, the
// ALU results are folded into a MISR signature. Overflow events and run cycles
// are also counted. At the end of the run the signature is compared with a
// golden value.
//
// Ports
//   clk         in   1       clock
//   rst         in   1       asynchronous active-high reset
//   start       in   1       one-cycle launch request (taken in IDLE / DONE)
//   pc_in       in   DATA_W  CPU program counter
//   alu_in      in   DATA_W  CPU ALU result
//   alu_ovf_in  in   1       CPU ALU overflow flag
//   cpu_rst     out  1       reset driven to the CPU (low only in RUN)
//   running     out  1       high in RUN
//   done        out  1       high in DONE
//   pass        out  1       run halted with the golden signature
//   timeout     out  1       run ended by timeout
//   cycles      out  16      RUN cycle count
//   signature   out  DATA_W  MISR value
//   ovf_count   out  8       saturating overflow event count
// -----------------------------------------------------------------------------
module cpu_run_monitor #(
    parameter int                 DATA_W     = 32,
    parameter int                 RST_CYCLES = 4,
    parameter int                 TIMEOUT    = 1024,
    parameter logic [DATA_W-1:0]  HALT_PC    = 32'h0000_00FC,
    parameter logic [DATA_W-1:0]  SIG_SEED   = 32'hFFFF_FFFF,
    parameter logic [DATA_W-1:0]  SIG_POLY   = 32'h04C1_1DB7,
    parameter logic [DATA_W-1:0]  EXPECT_SIG = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic              alu_ovf_in,
    output logic              cpu_rst,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       cycles,
    output logic [DATA_W-1:0] signature,
    output logic [7:0]        ovf_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESET = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // The down-counter is loaded with RST_CYCLES-1 on entry, so RESET lasts
    // exactly RST_CYCLES cycles including the terminal zero count.
    localparam logic [7:0]  C_RST_LOAD = 8'(RST_CYCLES - 1);
    // Comparing the count before the increment means the last permitted
    // run cycle is the one on which cycles reaches TIMEOUT.
    localparam logic [15:0] C_LAST_CYC = 16'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [7:0]        r_rst_cnt;
    logic [15:0]       r_cycles;
    logic [DATA_W-1:0] r_sig;
    logic [7:0]        r_ovf;
    logic              r_pass;
    logic              r_timeout;

    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_fold;
    logic              w_halt;
    logic              w_last;

    // MISR shift: bit 0 takes a zero, and every other bit takes its lower neighbour.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign w_shift[gi] = 1'b0;
            end else begin : g_bit
                assign w_shift[gi] = r_sig[gi-1];
            end
        end
    endgenerate

    assign w_fold = w_shift ^ (r_sig[DATA_W-1] ? SIG_POLY : '0) ^ alu_in;
    assign w_halt = (pc_in == HALT_PC);
    assign w_last = (r_cycles == C_LAST_CYC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rst_cnt <= '0;
            r_cycles  <= '0;
            r_sig     <= SIG_SEED;
            r_ovf     <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // A relaunch from DONE is identical to a launch from IDLE.
                    if (start) begin
                        r_state   <= S_RESET;
                        r_rst_cnt <= C_RST_LOAD;
                        r_cycles  <= '0;
                        r_sig     <= SIG_SEED;
                        r_ovf     <= '0;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (r_rst_cnt == 8'd0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - 8'd1;
                    end
                end
                S_RUN: begin
                    r_cycles <= r_cycles + 16'd1;
                    if (alu_ovf_in && (r_ovf != 8'hFF)) begin
                        r_ovf <= r_ovf + 8'd1;
                    end
                    if (w_halt) begin
                        // Halt has priority over timeout. The signature is frozen,
                        // and it is judged as it stood before this cycle.
                        r_state <= S_DONE;
                        r_pass  <= (r_sig == EXPECT_SIG);
                    end else begin
                        r_sig <= w_fold;
                        if (w_last) begin
                            r_state   <= S_DONE;
                            r_timeout <= 1'b1;
                            r_pass    <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu_rst   = (r_state != S_RUN);
    assign running   = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign cycles    = r_cycles;
    assign signature = r_sig;
    assign ovf_count = r_ovf;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_monitor
//
// Two instances share every input. The default instance (main) has
// TIMEOUT = 1024, and the second instance (t8) has TIMEOUT = 8. A small
// reference model follows each RUN cycle. When the model decides that a run
// has ended, it queues the expected final statistics. Each test task pops the
// queued results and compares them with the held DONE outputs.
// -----------------------------------------------------------------------------
module tb_cpu_run_monitor;

    localparam logic [31:0] HALT = 32'h0000_00FC;
    localparam logic [31:0] SEED = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [31:0] GOLD = 32'h0000_0000;
    localparam int          TO_MAIN = 1024;
    localparam int          TO_T    = 8;

    typedef struct packed {
        logic [15:0] cyc;
        logic [31:0] sig;
        logic        pass;
        logic        to;
        logic [7:0]  ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] pc_in;
    logic [31:0] alu_in;
    logic        alu_ovf_in;

    logic        m_cpu_rst, m_running, m_done, m_pass, m_timeout;
    logic [15:0] m_cycles;
    logic [31:0] m_sig;
    logic [7:0]  m_ovf;
    logic        t_cpu_rst, t_running, t_done, t_pass, t_timeout;
    logic [15:0] t_cycles;
    logic [31:0] t_sig;
    logic [7:0]  t_ovf;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q_main[$];
    exp_t q_t[$];

    // reference model state, index 0 = main, 1 = t8
    bit          mr[2];
    logic [15:0] mc[2];
    logic [31:0] ms[2];
    logic [7:0]  mo[2];

    cpu_run_monitor dut (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in), .alu_in(alu_in),
        .alu_ovf_in(alu_ovf_in), .cpu_rst(m_cpu_rst), .running(m_running),
        .done(m_done), .pass(m_pass), .timeout(m_timeout), .cycles(m_cycles),
        .signature(m_sig), .ovf_count(m_ovf)
    );

    cpu_run_monitor #(.TIMEOUT(TO_T)) dut_t (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in), .alu_in(alu_in),
        .alu_ovf_in(alu_ovf_in), .cpu_rst(t_cpu_rst), .running(t_running),
        .done(t_done), .pass(t_pass), .timeout(t_timeout), .cycles(t_cycles),
        .signature(t_sig), .ovf_count(t_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [31:0] a);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ a;
    endfunction

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_start;
        for (int d = 0; d < 2; d++) begin
            mr[d] = 1'b1; mc[d] = '0; ms[d] = SEED; mo[d] = '0;
        end
    endtask

    // Drive one RUN cycle, update the model, and queue the final result of
    // each instance whose run ends on this cycle.
    task automatic run_cycle(input logic [31:0] pc, input logic [31:0] alu, input logic ovf);
        exp_t e;
        pc_in = pc; alu_in = alu; alu_ovf_in = ovf;
        for (int d = 0; d < 2; d++) begin
            if (mr[d]) begin
                mc[d] = mc[d] + 16'd1;
                if (ovf && mo[d] != 8'hFF) mo[d] = mo[d] + 8'd1;
                if (pc == HALT) begin
                    e.cyc = mc[d]; e.sig = ms[d]; e.pass = (ms[d] == GOLD); e.to = 1'b0; e.ovf = mo[d];
                    mr[d] = 1'b0;
                    if (d == 0) q_main.push_back(e); else q_t.push_back(e);
                end else begin
                    ms[d] = sig_step(ms[d], alu);
                    if (int'(mc[d]) == ((d == 0) ? TO_MAIN : TO_T)) begin
                        e.cyc = mc[d]; e.sig = ms[d]; e.pass = 1'b0; e.to = 1'b1; e.ovf = mo[d];
                        mr[d] = 1'b0;
                        if (d == 0) q_main.push_back(e); else q_t.push_back(e);
                    end
                end
            end
        end
        step();
        alu_ovf_in = 1'b0;
    endtask

    task automatic launch;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        model_start();
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; pc_in = '0; alu_in = '0; alu_ovf_in = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m_cpu_rst, m_running, m_done, m_pass, m_timeout} !== 5'b10000) begin
            n_errors++;
            $display("FAIL reset_flags: got cpu_rst/running/done/pass/timeout=%b, expected 10000",
                     {m_cpu_rst, m_running, m_done, m_pass, m_timeout});
        end
        n_checks++;
        if ({m_cycles, m_ovf, m_sig} !== {16'd0, 8'd0, SEED}) begin
            n_errors++;
            $display("FAIL reset_stats: got cycles=%0d ovf=%0d sig=%h, expected 0 0 %h", m_cycles, m_ovf, m_sig, SEED);
        end
        $display("reset: cpu_rst=%b running=%b done=%b sig=%h", m_cpu_rst, m_running, m_done, m_sig);
    endtask

    task automatic test_idle_hold;
        rst = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({m_cpu_rst, m_running, m_done, t_cpu_rst, t_running, t_done} !== 6'b100100) begin
            n_errors++;
            $display("FAIL idle_hold: got %b, expected 100100", {m_cpu_rst, m_running, m_done, t_cpu_rst, t_running, t_done});
        end
        $display("idle_hold: cpu_rst=%b running=%b", m_cpu_rst, m_running);
    endtask

    task automatic test_launch;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({m_cpu_rst, m_running, t_cpu_rst, t_running} !== 4'b1010) begin
                n_errors++;
                $display("FAIL launch_reset_%0d: got cpu_rst/running=%b%b, expected 10", i, m_cpu_rst, m_running);
            end
            // A start that arrives in the middle of RESET has to be ignored.
            start = (i == 1);
            step();
            start = 1'b0;
        end
        n_checks++;
        if ({m_cpu_rst, m_running, m_cycles} !== {2'b01, 16'd0}) begin
            n_errors++;
            $display("FAIL launch_run: got cpu_rst=%b running=%b cycles=%0d, expected 0 1 0", m_cpu_rst, m_running, m_cycles);
        end
        model_start();
        run_cycle(32'h0, 32'h0, 1'b0);
        n_checks++;
        if ({m_running, m_cycles} !== {1'b1, 16'd1}) begin
            n_errors++;
            $display("FAIL launch_first_cycle: got running=%b cycles=%0d, expected 1 1", m_running, m_cycles);
        end
        $display("launch: running=%b cycles=%0d", m_running, m_cycles);
    endtask

    task automatic test_halt;
        exp_t e;
        logic [31:0] s;
        for (int k = 2; k <= 9; k++) run_cycle(32'h1000 + 32'(4 * k), 32'h0, 1'b0);
        run_cycle(HALT, 32'h0, 1'b0);
        s = SEED;
        for (int k = 0; k < 9; k++) s = sig_step(s, 32'h0);
        n_checks++;
        if ({m_done, m_cycles, m_sig, m_pass, m_timeout} !== {1'b1, 16'd10, s, (s == GOLD), 1'b0}) begin
            n_errors++;
            $display("FAIL halt_main: got done=%b cycles=%0d sig=%h pass=%b timeout=%b, expected 1 10 %h %b 0",
                     m_done, m_cycles, m_sig, m_pass, m_timeout, s, (s == GOLD));
        end
        n_checks++;
        if (q_main.size() == 0) begin
            n_errors++; $display("FAIL halt_main_sb: got no queued result, expected one");
        end else begin
            e = q_main.pop_front();
            if ({m_cycles, m_sig, m_pass, m_timeout, m_ovf} !== {e.cyc, e.sig, e.pass, e.to, e.ovf}) begin
                n_errors++;
                $display("FAIL halt_main_sb: got cycles=%0d sig=%h pass=%b to=%b ovf=%0d, expected %0d %h %b %b %0d",
                         m_cycles, m_sig, m_pass, m_timeout, m_ovf, e.cyc, e.sig, e.pass, e.to, e.ovf);
            end
        end
        // The TIMEOUT=8 instance never saw HALT_PC within its budget.
        n_checks++;
        if ({t_done, t_timeout, t_pass, t_cycles} !== {3'b110, 16'd8}) begin
            n_errors++;
            $display("FAIL halt_t8_timeout: got done=%b timeout=%b pass=%b cycles=%0d, expected 1 1 0 8", t_done, t_timeout, t_pass, t_cycles);
        end
        n_checks++;
        if (q_t.size() == 0) begin
            n_errors++; $display("FAIL halt_t8_sb: got no queued result, expected one");
        end else begin
            e = q_t.pop_front();
            if ({t_cycles, t_sig, t_pass, t_timeout, t_ovf} !== {e.cyc, e.sig, e.pass, e.to, e.ovf}) begin
                n_errors++;
                $display("FAIL halt_t8_sb: got cycles=%0d sig=%h pass=%b to=%b ovf=%0d, expected %0d %h %b %b %0d",
                         t_cycles, t_sig, t_pass, t_timeout, t_ovf, e.cyc, e.sig, e.pass, e.to, e.ovf);
            end
        end
        $display("halt: main cycles=%0d sig=%h pass=%b | t8 cycles=%0d timeout=%b", m_cycles, m_sig, m_pass, t_cycles, t_timeout);
    endtask

    task automatic test_timeout;
        exp_t e;
        launch();
        for (int k = 1; k <= 8; k++) run_cycle(32'h2000 + 32'(4 * k), $urandom(), 1'b0);
        n_checks++;
        if (q_t.size() == 0) begin
            n_errors++; $display("FAIL timeout_t8: got no queued result, expected one");
        end else begin
            e = q_t.pop_front();
            if ({t_done, t_cycles, t_sig, t_pass, t_timeout} !== {1'b1, e.cyc, e.sig, 1'b0, 1'b1}) begin
                n_errors++;
                $display("FAIL timeout_t8: got done=%b cycles=%0d sig=%h pass=%b to=%b, expected 1 %0d %h 0 1",
                         t_done, t_cycles, t_sig, t_pass, t_timeout, e.cyc, e.sig);
            end
        end
        n_checks++;
        if ({m_running, m_cycles} !== {1'b1, 16'd8}) begin
            n_errors++;
            $display("FAIL timeout_main_live: got running=%b cycles=%0d, expected 1 8", m_running, m_cycles);
        end
        run_cycle(HALT, $urandom(), 1'b0);
        n_checks++;
        if (q_main.size() == 0) begin
            n_errors++; $display("FAIL timeout_main: got no queued result, expected one");
        end else begin
            e = q_main.pop_front();
            if ({m_done, m_cycles, m_sig, m_pass, m_timeout} !== {1'b1, e.cyc, e.sig, e.pass, 1'b0}) begin
                n_errors++;
                $display("FAIL timeout_main: got done=%b cycles=%0d sig=%h pass=%b to=%b, expected 1 %0d %h %b 0",
                         m_done, m_cycles, m_sig, m_pass, m_timeout, e.cyc, e.sig, e.pass);
            end
        end
        $display("timeout: t8 cycles=%0d sig=%h timeout=%b | main cycles=%0d", t_cycles, t_sig, t_timeout, m_cycles);
    endtask

    // Run cycle 1 cancels the seed, so the signature becomes zero and stays
    // at the golden value. The halt on cycle 8 then collides with the t8 timeout.
    task automatic test_collision_pass;
        exp_t e;
        launch();
        run_cycle(32'h3000, sig_step(SEED, 32'h0), 1'b0);
        for (int k = 2; k <= 7; k++) run_cycle(32'h3000 + 32'(4 * k), 32'h0, 1'b0);
        run_cycle(HALT, 32'h0, 1'b0);
        n_checks++;
        if ({t_done, t_timeout, t_pass, t_cycles, t_sig} !== {3'b101, 16'd8, GOLD}) begin
            n_errors++;
            $display("FAIL collision_t8: got done=%b timeout=%b pass=%b cycles=%0d sig=%h, expected 1 0 1 8 %h",
                     t_done, t_timeout, t_pass, t_cycles, t_sig, GOLD);
        end
        n_checks++;
        if (q_t.size() == 0 || q_main.size() == 0) begin
            n_errors++; $display("FAIL collision_sb: got queue sizes %0d/%0d, expected 1/1", q_main.size(), q_t.size());
        end else begin
            e = q_main.pop_front();
            if ({m_done, m_cycles, m_sig, m_pass, m_timeout} !== {1'b1, e.cyc, e.sig, e.pass, e.to}) begin
                n_errors++;
                $display("FAIL collision_main: got done=%b cycles=%0d sig=%h pass=%b to=%b, expected 1 %0d %h %b %b",
                         m_done, m_cycles, m_sig, m_pass, m_timeout, e.cyc, e.sig, e.pass, e.to);
            end
            e = q_t.pop_front();
            if ({t_pass, t_timeout} !== {e.pass, e.to}) begin
                n_errors++;
                $display("FAIL collision_t8_sb: got pass=%b to=%b, expected %b %b", t_pass, t_timeout, e.pass, e.to);
            end
        end
        $display("collision: t8 timeout=%b pass=%b | main pass=%b cycles=%0d", t_timeout, t_pass, m_pass, m_cycles);
    endtask

    task automatic test_overflow;
        exp_t e;
        launch();
        for (int k = 1; k <= 300; k++) run_cycle(32'h4000 + 32'(4 * k), $urandom(), 1'b1);
        run_cycle(HALT, 32'h0, 1'b0);
        n_checks++;
        if ({m_done, m_ovf, m_cycles} !== {1'b1, 8'd255, 16'd301}) begin
            n_errors++;
            $display("FAIL overflow_main: got done=%b ovf=%0d cycles=%0d, expected 1 255 301", m_done, m_ovf, m_cycles);
        end
        n_checks++;
        if ({t_done, t_ovf, t_timeout} !== {1'b1, 8'd8, 1'b1}) begin
            n_errors++;
            $display("FAIL overflow_t8: got done=%b ovf=%0d timeout=%b, expected 1 8 1", t_done, t_ovf, t_timeout);
        end
        n_checks++;
        if (q_main.size() == 0 || q_t.size() == 0) begin
            n_errors++; $display("FAIL overflow_sb: got queue sizes %0d/%0d, expected 1/1", q_main.size(), q_t.size());
        end else begin
            e = q_main.pop_front();
            if ({m_sig, m_pass, m_ovf} !== {e.sig, e.pass, e.ovf}) begin
                n_errors++;
                $display("FAIL overflow_main_sb: got sig=%h pass=%b ovf=%0d, expected %h %b %0d", m_sig, m_pass, m_ovf, e.sig, e.pass, e.ovf);
            end
            e = q_t.pop_front();
            if ({t_sig, t_cycles} !== {e.sig, e.cyc}) begin
                n_errors++;
                $display("FAIL overflow_t8_sb: got sig=%h cycles=%0d, expected %h %0d", t_sig, t_cycles, e.sig, e.cyc);
            end
        end
        $display("overflow: main ovf=%0d cycles=%0d | t8 ovf=%0d", m_ovf, m_cycles, t_ovf);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({m_done, m_cycles, m_ovf, m_sig, m_pass, t_timeout, t_ovf} !== {1'b0, 16'd0, 8'd0, SEED, 1'b0, 1'b0, 8'd0}) begin
            n_errors++;
            $display("FAIL relaunch_clear: got done=%b cycles=%0d ovf=%0d sig=%h pass=%b t8_to=%b t8_ovf=%0d, expected 0 0 0 %h 0 0 0",
                     m_done, m_cycles, m_ovf, m_sig, m_pass, t_timeout, t_ovf, SEED);
        end
        repeat (4) step();
        model_start();
        for (int k = 1; k <= 3; k++) run_cycle(32'h5000 + 32'(4 * k), $urandom(), k[0]);
        run_cycle(HALT, 32'h0, 1'b1);
        n_checks++;
        if (q_main.size() == 0) begin
            n_errors++; $display("FAIL back_to_back: got no queued result, expected one");
        end else begin
            e = q_main.pop_front();
            if ({m_done, m_cycles, m_sig, m_pass, m_timeout, m_ovf} !== {1'b1, e.cyc, e.sig, e.pass, e.to, e.ovf}) begin
                n_errors++;
                $display("FAIL back_to_back: got done=%b cycles=%0d sig=%h pass=%b to=%b ovf=%0d, expected 1 %0d %h %b %b %0d",
                         m_done, m_cycles, m_sig, m_pass, m_timeout, m_ovf, e.cyc, e.sig, e.pass, e.to, e.ovf);
            end
        end
        void'(q_t.pop_front());
        $display("back_to_back: cycles=%0d sig=%h ovf=%0d", m_cycles, m_sig, m_ovf);
    endtask

    task automatic test_reset_midrun;
        exp_t e;
        launch();
        for (int k = 1; k <= 4; k++) run_cycle(32'h6000 + 32'(4 * k), $urandom(), 1'b0);
        rst = 1'b1;
        mr[0] = 1'b0; mr[1] = 1'b0;
        #1;
        n_checks++;
        if ({m_cpu_rst, m_running, m_done, m_pass, m_cycles, m_sig} !== {4'b1000, 16'd0, SEED}) begin
            n_errors++;
            $display("FAIL midrun_reset: got cpu_rst=%b running=%b done=%b pass=%b cycles=%0d sig=%h, expected 1 0 0 0 0 %h",
                     m_cpu_rst, m_running, m_done, m_pass, m_cycles, m_sig, SEED);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step();
        n_checks++;
        if ({m_cpu_rst, m_running, m_done, t_done} !== 4'b1000) begin
            n_errors++;
            $display("FAIL midrun_idle: got cpu_rst=%b running=%b done=%b t8_done=%b, expected 1 0 0 0", m_cpu_rst, m_running, m_done, t_done);
        end
        launch();
        for (int k = 1; k <= 5; k++) run_cycle(32'h7000 + 32'(4 * k), $urandom(), 1'b0);
        run_cycle(HALT, 32'h0, 1'b0);
        n_checks++;
        if (q_main.size() == 0) begin
            n_errors++; $display("FAIL midrun_rerun: got no queued result, expected one");
        end else begin
            e = q_main.pop_front();
            if ({m_done, m_cycles, m_sig, m_pass, m_timeout} !== {1'b1, e.cyc, e.sig, e.pass, e.to}) begin
                n_errors++;
                $display("FAIL midrun_rerun: got done=%b cycles=%0d sig=%h pass=%b to=%b, expected 1 %0d %h %b %b",
                         m_done, m_cycles, m_sig, m_pass, m_timeout, e.cyc, e.sig, e.pass, e.to);
            end
        end
        void'(q_t.pop_front());
        $display("reset_midrun: rerun cycles=%0d sig=%h", m_cycles, m_sig);
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_launch();
        test_halt();
        test_timeout();
        test_collision_pass();
        test_overflow();
        test_back_to_back();
        test_reset_midrun();
        n_checks++;
        if (q_main.size() != 0 || q_t.size() != 0) begin
            n_errors++;
            $display("FAIL leftover: got queue sizes %0d/%0d, expected 0/0", q_main.size(), q_t.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
